// File: rtl/i2s_pkg.sv
// Shared types and default widths for the I2S sample scheduler slice.
package i2s_pkg;

  localparam int unsigned DataWidth        = 12;
  localparam int unsigned SerialDataWidth  = 24;
  localparam int unsigned ScaleWidth       = 6;
  localparam int unsigned ClockConfigWidth = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECONFIG = 2'd1,
    ISSUE    = 2'd2,
    WAIT     = 2'd3
  } sched_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             inc,
  input  logic             clear,
  output logic [Width-1:0] count
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/i2s_sample_scheduler.sv
// Per-frame audio sequencer: ADC capture -> processing handshake -> DAC,
// with I2S config applied only between samples under a held i2sReset.
module i2s_sample_scheduler
  import i2s_pkg::*;
#(
  parameter int unsigned DataWidth        = i2s_pkg::DataWidth,
  parameter int unsigned ClockConfigWidth = i2s_pkg::ClockConfigWidth,
  parameter int unsigned ScaleWidth       = i2s_pkg::ScaleWidth,
  parameter int unsigned TimeoutWidth     = 16,
  parameter int unsigned ReconfigHold     = 4,
  parameter int unsigned CountWidth       = 8
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        cfgWrite,
  input  logic [ClockConfigWidth-1:0] cfgClockConfig,
  input  logic [ScaleWidth-1:0]       cfgAdcScale,
  input  logic [ScaleWidth-1:0]       cfgDacScale,
  output logic                        cfgPending,
  output logic [ClockConfigWidth-1:0] clockConfig,
  output logic [ScaleWidth-1:0]       adcScaleRaw,
  output logic [ScaleWidth-1:0]       dacScaleRaw,
  output logic                        i2sReset,
  input  logic [DataWidth-1:0]        adcData,
  input  logic                        adcValidPulse,
  input  logic                        bypass,
  output logic [DataWidth-1:0]        procData,
  output logic                        procValid,
  input  logic                        procReady,
  input  logic [DataWidth-1:0]        resData,
  input  logic                        resValid,
  output logic                        resReady,
  output logic [DataWidth-1:0]        dacData,
  input  logic [TimeoutWidth-1:0]     timeoutCycles,
  output logic [CountWidth-1:0]       overrunCount,
  output logic [CountWidth-1:0]       timeoutCount
);

  localparam int unsigned HoldWidth = $clog2(ReconfigHold + 1);
  localparam logic [HoldWidth-1:0] HoldLast = HoldWidth'(ReconfigHold - 1);

  sched_state_e state, stateNext;

  logic [HoldWidth-1:0]        holdCnt, holdNext;
  logic [TimeoutWidth-1:0]     timer, timerNext;
  logic [DataWidth-1:0]        sampleNext, dacNext;
  logic [ClockConfigWidth-1:0] shadowClock;
  logic [ScaleWidth-1:0]       shadowAdcScale, shadowDacScale;
  logic                        applyCfg, overrunInc, timeoutInc, timeoutHit;

  assign timeoutHit = (timeoutCycles != '0) &&
                      (timer == (timeoutCycles - TimeoutWidth'(1)));

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= RECONFIG;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and datapath decisions
  always_comb begin
    stateNext  = state;
    holdNext   = holdCnt;
    timerNext  = timer + TimeoutWidth'(1);
    sampleNext = procData;
    dacNext    = dacData;
    applyCfg   = 1'b0;
    overrunInc = 1'b0;
    timeoutInc = 1'b0;
    case (state)
      RECONFIG: begin
        overrunInc = adcValidPulse;
        if (holdCnt == HoldLast) begin
          stateNext = IDLE;
        end else begin
          holdNext = holdCnt + HoldWidth'(1);
        end
      end
      IDLE: begin
        if (cfgPending) begin
          applyCfg  = 1'b1;
          holdNext  = '0;
          stateNext = RECONFIG;
        end else if (adcValidPulse) begin
          if (bypass) begin
            dacNext = adcData;
          end else begin
            sampleNext = adcData;
            timerNext  = '0;
            stateNext  = ISSUE;
          end
        end
      end
      ISSUE: begin
        overrunInc = adcValidPulse;
        if (procReady) begin
          stateNext = WAIT;
        end else if (timeoutHit) begin
          timeoutInc = 1'b1;
          stateNext  = IDLE;
        end
      end
      WAIT: begin
        overrunInc = adcValidPulse;
        if (resValid) begin
          dacNext   = resData;
          stateNext = IDLE;
        end else if (timeoutHit) begin
          timeoutInc = 1'b1;
          stateNext  = IDLE;
        end
      end
      default: stateNext = RECONFIG;
    endcase
  end

  // Datapath and handshake registers; strobes track the next state
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      holdCnt   <= '0;
      timer     <= '0;
      procData  <= '0;
      dacData   <= '0;
      procValid <= 1'b0;
      resReady  <= 1'b0;
      i2sReset  <= 1'b1;
    end else begin
      holdCnt   <= holdNext;
      timer     <= timerNext;
      procData  <= sampleNext;
      dacData   <= dacNext;
      procValid <= (stateNext == ISSUE);
      resReady  <= (stateNext == WAIT);
      i2sReset  <= (stateNext == RECONFIG);
    end
  end

  // Shadow/applied config; an apply consumes the shadow as it was before this edge
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shadowClock    <= '0;
      shadowAdcScale <= '0;
      shadowDacScale <= '0;
      clockConfig    <= '0;
      adcScaleRaw    <= '0;
      dacScaleRaw    <= '0;
      cfgPending     <= 1'b0;
    end else begin
      if (applyCfg) begin
        clockConfig <= shadowClock;
        adcScaleRaw <= shadowAdcScale;
        dacScaleRaw <= shadowDacScale;
      end
      if (cfgWrite) begin
        shadowClock    <= cfgClockConfig;
        shadowAdcScale <= cfgAdcScale;
        shadowDacScale <= cfgDacScale;
      end
      cfgPending <= cfgWrite | (cfgPending & ~applyCfg);
    end
  end

  sat_counter #(.Width(CountWidth)) uOverrunCounter (
    .clk    (clk),
    .resetN (resetN),
    .inc    (overrunInc),
    .clear  (1'b0),
    .count  (overrunCount)
  );

  sat_counter #(.Width(CountWidth)) uTimeoutCounter (
    .clk    (clk),
    .resetN (resetN),
    .inc    (timeoutInc),
    .clear  (1'b0),
    .count  (timeoutCount)
  );

endmodule
